// File: rtl/cfg_mult_arbiter.sv
// rtl/cfg_mult_arbiter.sv - round-robin share of one configurable multiplier; optional WAIT timeout via CFG_MULT_TIMEOUT_EN
module cfg_mult_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [16*NUM_REQ-1:0] req_a_i,
    input  logic [16*NUM_REQ-1:0] req_b_i,
    input  logic [2*NUM_REQ-1:0]  req_cm_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [31:0]           rsp_product_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic [15:0]           mul_multiplicand_o,
    output logic [15:0]           mul_multiplier_o,
    output logic [1:0]            mul_cm_o,
    output logic                  mul_enable_o,
    input  logic [31:0]           mul_product_i,
    input  logic                  mul_data_valid_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [15:0]         r_a;
    logic [15:0]         r_b;
    logic [1:0]          r_cm;
    logic                r_first;
    logic [31:0]         r_product;
    logic                r_err;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_gnt_any;
    logic [15:0]         w_gnt_a;
    logic [15:0]         w_gnt_b;
    logic [1:0]          w_gnt_cm;
    logic                w_accept;
    logic                w_capture;
    logic                w_timeout;
    logic [NUM_REQ-1:0]  w_ready;

    // Grant search: first valid requester at or above the pointer, wrapping around
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_any && req_valid_i[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_gnt_a   = req_a_i[16*int'(w_gnt_idx) +: 16];
    assign w_gnt_b   = req_b_i[16*int'(w_gnt_idx) +: 16];
    assign w_gnt_cm  = req_cm_i[2*int'(w_gnt_idx) +: 2];
    assign w_accept  = (r_state == S_IDLE) && w_gnt_any && reset_ni;
    // The first WAIT cycle may still see a valid left over from the previous op
    assign w_capture = (r_state == S_WAIT) && !r_first && mul_data_valid_i;

`ifdef CFG_MULT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;

    assign w_timeout = (r_state == S_WAIT) && !w_capture &&
                       (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter, cleared whenever a new op enters WAIT
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_tmo <= '0;
        end else if (w_accept) begin
            r_tmo <= '0;
        end else if (r_state == S_WAIT) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next state and the one-cycle accept strobe
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_ready[w_gnt_idx] = 1'b1;
                    w_state_nxt = (w_gnt_cm == 2'b11) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_capture || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand/tag capture on accept, result capture at the end of WAIT
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cm      <= '0;
            r_first   <= 1'b0;
            r_product <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_a       <= w_gnt_a;
            r_b       <= w_gnt_b;
            r_cm      <= w_gnt_cm;
            r_id      <= w_gnt_idx;
            r_ptr     <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_first   <= 1'b1;
            r_product <= '0;
            r_err     <= (w_gnt_cm == 2'b11);
        end else if (r_state == S_WAIT) begin
            r_first <= 1'b0;
            if (w_capture) begin
                r_product <= mul_product_i;
                r_err     <= 1'b0;
            end else if (w_timeout) begin
                r_product <= '0;
                r_err     <= 1'b1;
            end
        end
    end

    assign req_ready_o        = w_ready;
    assign rsp_valid_o        = (r_state == S_RESP);
    assign rsp_id_o           = r_id;
    assign rsp_product_o      = r_product;
    assign rsp_err_o          = r_err;
    assign busy_o             = (r_state != S_IDLE);
    assign mul_multiplicand_o = r_a;
    assign mul_multiplier_o   = r_b;
    assign mul_cm_o           = r_cm;
    assign mul_enable_o       = (r_state == S_WAIT);

endmodule

// File: tb/tb_cfg_mult_arbiter.sv
// tb/tb_cfg_mult_arbiter.sv - self-checking bench for cfg_mult_arbiter with multiplier stub and reference model
module tb_cfg_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk_i = 1'b0;
    logic                  reset_ni = 1'b0;
    logic [NUM_REQ-1:0]    req_valid_i = '0;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [16*NUM_REQ-1:0] req_a_i = '0;
    logic [16*NUM_REQ-1:0] req_b_i = '0;
    logic [2*NUM_REQ-1:0]  req_cm_i = '0;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i = 1'b0;
    logic [ID_W-1:0]       rsp_id_o;
    logic [31:0]           rsp_product_o;
    logic                  rsp_err_o;
    logic                  busy_o;
    logic [15:0]           mul_multiplicand_o;
    logic [15:0]           mul_multiplier_o;
    logic [1:0]            mul_cm_o;
    logic                  mul_enable_o;
    logic [31:0]           mul_product_i = '0;
    logic                  mul_data_valid_i = 1'b0;

    cfg_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_cm_i(req_cm_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_product_o(rsp_product_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .mul_multiplicand_o(mul_multiplicand_o), .mul_multiplier_o(mul_multiplier_o),
        .mul_cm_o(mul_cm_o), .mul_enable_o(mul_enable_o),
        .mul_product_i(mul_product_i), .mul_data_valid_i(mul_data_valid_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mul_ref(input logic [15:0] a, input logic [15:0] b, input logic [1:0] cm);
        int sa;
        int sb;
        case (cm)
            2'b00: return {16'h0, 16'(a[7:0]) * 16'(b[7:0])};
            2'b01: return {16'(a[15:8]) * 16'(b[15:8]), 16'(a[7:0]) * 16'(b[7:0])};
            2'b10: begin
                sa = int'(signed'(a));
                sb = int'(signed'(b));
                return 32'(sa * sb);
            end
            default: return 32'h0;
        endcase
    endfunction

    // Multiplier stub: random latency, optional stale valid in the first enabled cycle
    int stub_cnt = 0;
    int stub_lat = 1;
    bit stub_glitch = 1'b0;
    bit stub_never = 1'b0;
    always @(negedge clk_i) begin
        if (!reset_ni || !mul_enable_o) begin
            stub_cnt = 0;
            mul_data_valid_i = 1'b0;
            mul_product_i = '0;
        end else begin
            stub_cnt++;
            if (stub_cnt == 1) begin
                stub_lat = $urandom_range(1, 4);
                stub_glitch = ($urandom_range(0, 1) == 1);
            end
            if (stub_never) begin
                mul_data_valid_i = 1'b0;
                mul_product_i = '0;
            end else if (stub_cnt == 1 && stub_glitch) begin
                mul_data_valid_i = 1'b1;
                mul_product_i = 32'hDEAD_BEEF;
            end else if (stub_cnt >= 1 + stub_lat) begin
                mul_data_valid_i = 1'b1;
                mul_product_i = mul_ref(mul_multiplicand_o, mul_multiplier_o, mul_cm_o);
            end else begin
                mul_data_valid_i = 1'b0;
                mul_product_i = '0;
            end
        end
    end

    int en_seen = 0;
    always @(negedge clk_i) if (mul_enable_o) en_seen++;

    // Reference model: one op in flight, round-robin pointer, queue of expected responses
    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     prod;
        logic            err;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t m_e;
    int m_ptr = 0;
    int m_g = 0;
    bit m_idle = 1'b1;
    bit m_found = 1'b0;
    bit tmo_mode = 1'b0;
    logic [NUM_REQ-1:0] m_rdy;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [1:0] m_cm;

    always @(negedge clk_i) begin
        if (!reset_ni) begin
            exp_q.delete();
            m_ptr = 0;
            m_idle = 1'b1;
        end else begin
            check("busy", busy_o, !m_idle);
            m_rdy = '0;
            m_found = 1'b0;
            if (m_idle) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!m_found && req_valid_i[(m_ptr + i) % NUM_REQ]) begin
                        m_found = 1'b1;
                        m_g = (m_ptr + i) % NUM_REQ;
                    end
                end
                if (m_found) m_rdy[m_g] = 1'b1;
            end
            check("req_ready", req_ready_o, m_rdy);
            if (m_found) begin
                m_a = req_a_i[16*m_g +: 16];
                m_b = req_b_i[16*m_g +: 16];
                m_cm = req_cm_i[2*m_g +: 2];
                m_e.id = ID_W'(m_g);
                m_e.err = (m_cm == 2'b11) || tmo_mode;
                m_e.prod = m_e.err ? 32'h0 : mul_ref(m_a, m_b, m_cm);
                exp_q.push_back(m_e);
                m_ptr = (m_g + 1) % NUM_REQ;
                m_idle = 1'b0;
            end
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_valid_o, 1'b0);
                end else begin
                    check("rsp_id", rsp_id_o, exp_q[0].id);
                    check("rsp_product", rsp_product_o, exp_q[0].prod);
                    check("rsp_err", rsp_err_o, exp_q[0].err);
                    check("enable_in_resp", mul_enable_o, 1'b0);
                    if (rsp_ready_i) begin
                        void'(exp_q.pop_front());
                        m_idle = 1'b1;
                    end
                end
            end
        end
    end

    task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b, input logic [1:0] cm);
        req_a_i[16*k +: 16] = a;
        req_b_i[16*k +: 16] = b;
        req_cm_i[2*k +: 2] = cm;
        req_valid_i[k] = 1'b1;
    endtask

    task automatic wait_accept(input int k);
        bit got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk_i);
            if (req_ready_o[k]) got = 1'b1;
        end
        check("accept_timeout", got, 1'b1);
        @(posedge clk_i);
        #1;
        req_valid_i[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int limit);
        bit got = 1'b0;
        for (int c = 0; c < limit && !got; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o) got = 1'b1;
        end
        check("rsp_timeout", got, 1'b1);
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk_i);
            if (!busy_o && exp_q.size() == 0) got = 1'b1;
        end
        check("drain", got, 1'b1);
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  cm;
        logic [31:0] prod;
        logic        err;
    } vec_t;
    vec_t vt[8];

    int order[5];
    int n_gnt;
    int rsp_seen;
    logic [NUM_REQ-1:0] acc;

    initial begin
        vt[0] = '{0, 16'hFFFE, 16'h0003, 2'b10, 32'hFFFF_FFFA, 1'b0};
        vt[1] = '{1, 16'h0203, 16'h0405, 2'b01, 32'h0008_000F, 1'b0};
        vt[2] = '{2, 16'h1234, 16'h5678, 2'b11, 32'h0000_0000, 1'b1};
        vt[3] = '{3, 16'h12FF, 16'h34FF, 2'b00, 32'h0000_FE01, 1'b0};
        vt[4] = '{0, 16'h8000, 16'h8000, 2'b10, 32'h4000_0000, 1'b0};
        vt[5] = '{2, 16'h7FFF, 16'h8000, 2'b10, 32'hC000_8000, 1'b0};
        vt[6] = '{1, 16'hFFFF, 16'hFFFF, 2'b01, 32'hFE01_FE01, 1'b0};
        vt[7] = '{3, 16'hFFFF, 16'h0000, 2'b00, 32'h0000_0000, 1'b0};

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ctrl", {req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, busy_o, mul_cm_o, mul_enable_o}, 32'h0);
        check("rst_product", rsp_product_o, 32'h0);
        check("rst_operands", {mul_multiplicand_o, mul_multiplier_o}, 32'h0);
        reset_ni = 1'b1;

        // Round robin with all requesters continuously valid
        rsp_ready_i = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 16'(k + 3), 16'h0011, 2'b10);
        n_gnt = 0;
        for (int c = 0; c < 400 && n_gnt < 5; c++) begin
            @(negedge clk_i);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_ready_o[k]) begin
                    order[n_gnt] = k;
                    n_gnt++;
                end
            end
        end
        @(posedge clk_i);
        #1;
        req_valid_i = '0;
        check("rr_count", n_gnt, 5);
        check("rr_g0", order[0], 0);
        check("rr_g1", order[1], 1);
        check("rr_g2", order[2], 2);
        check("rr_g3", order[3], 3);
        check("rr_g4", order[4], 0);
        wait_idle();

        // Directed vectors
        for (int v = 0; v < 8; v++) begin
            en_seen = 0;
            set_req(vt[v].k, vt[v].a, vt[v].b, vt[v].cm);
            wait_accept(vt[v].k);
            wait_rsp(100);
            check($sformatf("vec%0d_id", v), rsp_id_o, vt[v].k);
            check($sformatf("vec%0d_product", v), rsp_product_o, vt[v].prod);
            check($sformatf("vec%0d_err", v), rsp_err_o, vt[v].err);
            if (vt[v].err) check($sformatf("vec%0d_no_enable", v), en_seen, 0);
            else check($sformatf("vec%0d_enable_min", v), (en_seen >= 2), 1'b1);
            @(posedge clk_i);
            #1;
        end
        wait_idle();

        // Back-pressure: response held for 10 cycles with another requester waiting
        rsp_ready_i = 1'b0;
        set_req(0, 16'hFFFE, 16'h0003, 2'b10);
        wait_accept(0);
        set_req(1, 16'h0101, 16'h0202, 2'b00);
        wait_rsp(100);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk_i);
            check("bp_valid", rsp_valid_o, 1'b1);
            check("bp_product", rsp_product_o, 32'hFFFF_FFFA);
            check("bp_id", rsp_id_o, 0);
            check("bp_ready", req_ready_o, 0);
            check("bp_enable", mul_enable_o, 1'b0);
        end
        @(posedge clk_i);
        #1;
        req_valid_i[1] = 1'b0;
        rsp_ready_i = 1'b1;
        wait_idle();

        // Asynchronous reset while the multiplier is enabled
        stub_never = 1'b1;
        set_req(3, 16'h1111, 16'h2222, 2'b10);
        wait_accept(3);
        repeat (3) @(negedge clk_i);
        check("mid_wait_enable", mul_enable_o, 1'b1);
        #2;
        reset_ni = 1'b0;
        #1;
        check("arst_ctrl", {req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, busy_o, mul_cm_o, mul_enable_o}, 32'h0);
        check("arst_product", rsp_product_o, 32'h0);
        check("arst_operands", {mul_multiplicand_o, mul_multiplier_o}, 32'h0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        stub_never = 1'b0;
        rsp_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o || busy_o) rsp_seen++;
        end
        check("arst_no_rsp", rsp_seen, 0);
        @(posedge clk_i);
        #1;

`ifdef CFG_MULT_TIMEOUT_EN
        // Multiplier that never answers
        stub_never = 1'b1;
        tmo_mode = 1'b1;
        en_seen = 0;
        set_req(1, 16'h0005, 16'h0006, 2'b00);
        wait_accept(1);
        wait_rsp(300);
        check("tmo_cycles", en_seen, 64);
        check("tmo_err", rsp_err_o, 1'b1);
        check("tmo_product", rsp_product_o, 32'h0);
        check("tmo_id", rsp_id_o, 1);
        @(posedge clk_i);
        #1;
        wait_idle();
        tmo_mode = 1'b0;
        stub_never = 1'b0;
`endif

        // Random traffic with withdrawals and random back-pressure
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            acc = req_ready_o & req_valid_i;
            @(posedge clk_i);
            #1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (acc[k]) begin
                    req_valid_i[k] = 1'b0;
                end else if (!req_valid_i[k]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(k, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid_i[k] = 1'b0;
                end
            end
            rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
